regbank_reader: RTL

Read-side companion to the `regBank` write path. It selects two operands from the eight register outputs `R0`–`R7` per accepted request. When the bank is writing the same register in the same cycle, it forwards the write data instead of the stale value. Results are buffered in a 2-entry output queue with valid/ready handshake toward the ALU/operand consumer. A `DUMP` mode sequentially streams all eight registers out through the same queue for debug and trace.

---
 rtl/regbank_pkg.sv | 15 +
 rtl/regbank_reader_if.sv | 29 ++
 rtl/regbank_reader_opq2.sv | 89 ++++++++
 rtl/regbank_reader.sv | 115 +++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and encodings for the register bank and its read-side companion.
package regbank_pkg;

    localparam int NREGS = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    localparam logic K_OPER = 1'b0;
    localparam logic K_DUMP = 1'b1;

endpackage

// File: rtl/regbank_reader_if.sv
// Operand request / result handshake bundle between requester, reader and consumer.
interface regbank_reader_if #(
    parameter int DATA_W = 8
);
    import regbank_pkg::*;

    logic              REQ_V;
    logic              REQ_R;
    logic [SEL_W-1:0]  SA;
    logic [SEL_W-1:0]  SB;
    logic              OUT_V;
    logic              OUT_R;
    logic [DATA_W-1:0] OPA;
    logic [DATA_W-1:0] OPB;
    logic              OUT_K;

    // The reader side: takes requests, produces queued operands.
    modport slave (
        input  REQ_V, SA, SB, OUT_R,
        output REQ_R, OUT_V, OPA, OPB, OUT_K
    );

    // The requester/consumer side.
    modport master (
        output REQ_V, SA, SB, OUT_R,
        input  REQ_R, OUT_V, OPA, OPB, OUT_K
    );

endinterface

// File: rtl/regbank_reader_opq2.sv
// Two-entry FIFO of {kind, A, B}; slot 0 is always the head so outputs are direct register taps.
module opq2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              kind_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [1:0]        count_o,
    output logic              valid_o,
    output logic              kind_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o
);

    logic [1:0]        count_q, count_d;
    logic              kind0_q, kind0_d, kind1_q, kind1_d;
    logic [DATA_W-1:0] a0_q, a0_d, a1_q, a1_d;
    logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
    logic              doPop, doPush;

    // Next-state of both slots; a pop shifts slot 1 forward, an empty queue keeps its stale head.
    always_comb begin
        kind0_d = kind0_q;
        a0_d    = a0_q;
        b0_d    = b0_q;
        kind1_d = kind1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        count_d = count_q;
        doPop   = pop_i && (count_q != 2'd0);
        doPush  = push_i && ((count_q != 2'd2) || doPop);

        if (doPop && (count_q == 2'd2)) begin
            kind0_d = kind1_q;
            a0_d    = a1_q;
            b0_d    = b1_q;
        end

        if (doPush) begin
            if ((count_q == 2'd0) || (doPop && (count_q == 2'd1))) begin
                kind0_d = kind_i;
                a0_d    = a_i;
                b0_d    = b_i;
            end else begin
                kind1_d = kind_i;
                a1_d    = a_i;
                b1_d    = b_i;
            end
        end

        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 2'd1;
        end
    end

    // Slot and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            kind0_q <= 1'b0;
            a0_q    <= '0;
            b0_q    <= '0;
            kind1_q <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
        end else begin
            count_q <= count_d;
            kind0_q <= kind0_d;
            a0_q    <= a0_d;
            b0_q    <= b0_d;
            kind1_q <= kind1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign kind_o  = kind0_q;
    assign a_o     = a0_q;
    assign b_o     = b0_q;

endmodule

// File: rtl/regbank_reader.sv
// Read side of the register bank: bypassed operand selects, debug dump sequencer, 2-deep output queue.
module regbank_reader
    import regbank_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] R0,
    input  logic [DATA_W-1:0] R1,
    input  logic [DATA_W-1:0] R2,
    input  logic [DATA_W-1:0] R3,
    input  logic [DATA_W-1:0] R4,
    input  logic [DATA_W-1:0] R5,
    input  logic [DATA_W-1:0] R6,
    input  logic [DATA_W-1:0] R7,
    input  logic              WR_E,
    input  logic [SEL_W-1:0]  WR_S,
    input  logic [DATA_W-1:0] WR_D,
    input  logic              DUMP_GO,
    output logic              DUMP_BUSY,
    regbank_reader_if.slave   bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rdA, rdB, rdD;
    logic [DATA_W-1:0] pushA, pushB;
    logic              pushK;
    state_t            state_q;
    logic [SEL_W-1:0]  idx_q;
    logic [1:0]        count;
    logic              pop, reqAcc, dumpPush, push;

    assign regs[0] = R0;
    assign regs[1] = R1;
    assign regs[2] = R2;
    assign regs[3] = R3;
    assign regs[4] = R4;
    assign regs[5] = R5;
    assign regs[6] = R6;
    assign regs[7] = R7;

    // Three 8:1 selects, each forwarding the in-flight write when it targets the same register.
    always_comb begin
        rdA = (WR_E && (WR_S == bus.SA)) ? WR_D : regs[bus.SA];
        rdB = (WR_E && (WR_S == bus.SB)) ? WR_D : regs[bus.SB];
        rdD = (WR_E && (WR_S == idx_q))  ? WR_D : regs[idx_q];
    end

    // Ready is deliberately blind to the consumer, so a full queue costs one bubble even when draining.
    assign bus.REQ_R = !RST && (state_q == ST_IDLE) && (count < 2'd2) && !DUMP_GO;
    assign pop       = bus.OUT_V && bus.OUT_R;
    assign reqAcc    = bus.REQ_V && bus.REQ_R;
    assign dumpPush  = (state_q == ST_DUMP) && ((count < 2'd2) || pop);
    assign push      = reqAcc || dumpPush;

    // Queue entry source: dump beats carry the register index in B, requests carry both operands.
    always_comb begin
        pushK = K_OPER;
        pushA = rdA;
        pushB = rdB;
        if (state_q == ST_DUMP) begin
            pushK = K_DUMP;
            pushA = rdD;
            pushB = DATA_W'(idx_q);
        end
    end

    // Mode sequencer: one dump walks idx 0..7, stalling on a full queue, then falls back to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (DUMP_GO) begin
                        state_q <= ST_DUMP;
                        idx_q   <= '0;
                    end
                end
                ST_DUMP: begin
                    if (dumpPush) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'(NREGS - 1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign DUMP_BUSY = (state_q == ST_DUMP);

    opq2 #(.DATA_W(DATA_W)) u_opq2 (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (push),
        .pop_i   (pop),
        .kind_i  (pushK),
        .a_i     (pushA),
        .b_i     (pushB),
        .count_o (count),
        .valid_o (bus.OUT_V),
        .kind_o  (bus.OUT_K),
        .a_o     (bus.OPA),
        .b_o     (bus.OPB)
    );

endmodule
